// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle CPU control path.
//   - opcode constants (IR[31:26])
//   - FSM state encodings; the numeric values are visible on the debug port
//   - ALUOp, PCSource, RegDst and MemtoReg select encodings
package mcpu_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_MA  = 4'd2,
        S_MRD = 4'd3,
        S_LWB = 4'd4,
        S_MWR = 4'd5,
        S_REX = 4'd6,
        S_RWB = 4'd7,
        S_BR  = 4'd8,
        S_JMP = 4'd9,
        S_IEX = 4'd10,
        S_IWB = 4'd11,
        S_JAL = 4'd12
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

endpackage

// File: rtl/mcpu_ctrl_fsm.sv
// Main control FSM of the multi-cycle CPU.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// register enables, mux selects and memory strobes as Moore decodes of state.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode            IR[31:26]; sampled only in S_ID, S_MA, S_BR, S_IEX
//   zero              ALU zero flag (branch is resolved in the datapath)
//   mem_ready         memory completes the current access this cycle
//   PCWrite..PCSource datapath enables, selects and memory strobes
//   state             current state, for debug
//   illegal_op        one-cycle pulse on an undefined opcode in S_ID
//   mem_err           one-cycle pulse when a memory access times out
//
// Memory handshake: MemRead/MemWrite are held for the whole access; the
// access ends in the first cycle with mem_ready=1, and only that cycle
// asserts the enable that captures the result (IRWrite/PCWrite/MDRWrite) and
// leaves the wait state. If the wait lasts MEM_TIMEOUT cycles the access is
// abandoned: mem_err pulses, no enable fires, and fetch restarts.
module mcpu_ctrl_fsm
    import mcpu_pkg::*;
#(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MDRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_err
);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       in_wait;
    logic       timeout;

    // The branch decision (zero vs BranchNE) is made next to the PC register.
    logic unused_zero;
    assign unused_zero = zero;

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IF;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MDRWrite    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = RD_RT;
        MemtoReg    = M2R_ALU;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALU_ADD;
        PCSource    = PCS_ALU;
        illegal_op  = 1'b0;
        mem_err     = 1'b0;

        in_wait = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);
        timeout = in_wait && (wait_cnt_q == MEM_TIMEOUT);

        // Counts only stalled cycles; any exit from the wait state clears it.
        wait_cnt_d = 8'd0;
        if (in_wait && !mem_ready && !timeout) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_R:                            state_d = S_REX;
                    OP_LW, OP_SW:                    state_d = S_MA;
                    OP_BEQ, OP_BNE:                  state_d = S_BR;
                    OP_J:                            state_d = S_JMP;
                    OP_JAL:                          state_d = S_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEX;
                    default: begin
                        state_d    = S_IF;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MA: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_LW)      state_d = S_MRD;
                else if (opcode == OP_SW) state_d = S_MWR;
                else                      state_d = S_IF;
            end
            S_MRD: begin
                MemRead  = 1'b1;
                IorD     = 1'b1;
                MDRWrite = mem_ready;
                if (mem_ready) state_d = S_LWB;
            end
            S_LWB: begin
                RegWrite = 1'b1;
                MemtoReg = M2R_MDR;
                state_d  = S_IF;
            end
            S_MWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) state_d = S_IF;
            end
            S_REX: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = RD_RD;
                state_d  = S_IF;
            end
            S_BR: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                BranchNE    = (opcode == OP_BNE);
                PCSource    = PCS_ALUOUT;
                state_d     = S_IF;
            end
            S_JMP: begin
                PCWrite  = 1'b1;
                PCSource = PCS_JUMP;
                state_d  = S_IF;
            end
            S_IEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (opcode)
                    OP_ANDI: ALUOp = ALU_AND;
                    OP_ORI:  ALUOp = ALU_OR;
                    OP_SLTI: ALUOp = ALU_SLT;
                    default: ALUOp = ALU_ADD;
                endcase
                state_d = S_IWB;
            end
            S_IWB: begin
                RegWrite = 1'b1;
                state_d  = S_IF;
            end
            S_JAL: begin
                // PC already holds PC+4 from fetch; r31 and PC update on the same edge.
                RegWrite = 1'b1;
                RegDst   = RD_R31;
                MemtoReg = M2R_PC;
                PCWrite  = 1'b1;
                PCSource = PCS_JUMP;
                state_d  = S_IF;
            end
            default: state_d = S_IF;
        endcase

        if (timeout) begin
            state_d     = S_IF;
            mem_err     = 1'b1;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MDRWrite    = 1'b0;
            RegWrite    = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
        end

        // Reset also silences the decode of S_IF so nothing strobes memory.
        if (!rst_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            BranchNE    = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MDRWrite    = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 2'b00;
            MemtoReg    = 2'b00;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 3'b000;
            PCSource    = 2'b00;
            illegal_op  = 1'b0;
            mem_err     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Bench for mcpu_ctrl_fsm. The reference model expands each instruction into
// the list of (state, mem_ready) cycles it should take, then looks up the
// expected control word for each cycle in a table written from the state list.
module tb_mcpu_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite;
    logic       IRWrite, MDRWrite, RegWrite, ALUSrcA;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] state;
    logic       illegal_op, mem_err;

    logic [20:0] ctrl_w;
    assign ctrl_w = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite,
                     IRWrite, MDRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
                     ALUSrcB, ALUOp, PCSource};

    mcpu_ctrl_fsm #(.MEM_TIMEOUT(8'd4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .BranchNE(BranchNE), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MDRWrite(MDRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .illegal_op(illegal_op),
        .mem_err(mem_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int C_ILL = 0, C_R = 1, C_LW = 2, C_SW = 3, C_BR = 4,
                   C_J = 5, C_JAL = 6, C_IMM = 7;

    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'd0:            return C_R;
            6'd35:           return C_LW;
            6'd43:           return C_SW;
            6'd4, 6'd5:      return C_BR;
            6'd2:            return C_J;
            6'd3:            return C_JAL;
            6'd8, 6'd12, 6'd13, 6'd10: return C_IMM;
            default:         return C_ILL;
        endcase
    endfunction

    // Control word expected in a given state, straight from the state table.
    function automatic logic [20:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op, input logic mr);
        logic pcw, pcwc, bne, iord, mrd, mwr, irw, mdrw, rw, srca;
        logic [1:0] rdst, m2r, srcb, pcs;
        logic [2:0] aop;
        {pcw, pcwc, bne, iord, mrd, mwr, irw, mdrw, rw, srca} = '0;
        {rdst, m2r, srcb, pcs} = '0;
        aop = 3'b000;
        case (st)
            4'd0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            4'd1:  begin srcb = 2'b11; end
            4'd2:  begin srca = 1; srcb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; mdrw = mr; end
            4'd4:  begin rw = 1; m2r = 2'b01; end
            4'd5:  begin mwr = 1; iord = 1; end
            4'd6:  begin srca = 1; aop = 3'b010; end
            4'd7:  begin rw = 1; rdst = 2'b01; end
            4'd8:  begin srca = 1; aop = 3'b001; pcwc = 1; bne = (op == 6'd5); pcs = 2'b01; end
            4'd9:  begin pcw = 1; pcs = 2'b10; end
            4'd10: begin
                srca = 1; srcb = 2'b10;
                aop = (op == 6'd12) ? 3'b011 : (op == 6'd13) ? 3'b100 :
                      (op == 6'd10) ? 3'b101 : 3'b000;
            end
            4'd11: begin rw = 1; end
            4'd12: begin rw = 1; rdst = 2'b10; m2r = 2'b10; pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, bne, iord, mrd, mwr, irw, mdrw, rw, rdst, m2r, srca, srcb, aop, pcs};
    endfunction

    // ---------------- scoreboard ----------------
    logic [4:0] exp_q[$];   // {mem_ready to drive, expected state}

    task automatic push(input logic [3:0] st, input logic mr);
        exp_q.push_back({mr, st});
    endtask

    task automatic build_seq(input logic [5:0] op, input int w_if, input int w_mem);
        for (int i = 0; i < w_if; i++) push(4'd0, 1'b0);
        push(4'd0, 1'b1);
        push(4'd1, 1'($urandom_range(0, 1)));
        case (op_class(op))
            C_R:   begin push(4'd6, 1'($urandom_range(0, 1))); push(4'd7, 1'($urandom_range(0, 1))); end
            C_LW: begin
                push(4'd2, 1'($urandom_range(0, 1)));
                for (int i = 0; i < w_mem; i++) push(4'd3, 1'b0);
                push(4'd3, 1'b1);
                push(4'd4, 1'($urandom_range(0, 1)));
            end
            C_SW: begin
                push(4'd2, 1'($urandom_range(0, 1)));
                for (int i = 0; i < w_mem; i++) push(4'd5, 1'b0);
                push(4'd5, 1'b1);
            end
            C_BR:  push(4'd8, 1'($urandom_range(0, 1)));
            C_J:   push(4'd9, 1'($urandom_range(0, 1)));
            C_JAL: push(4'd12, 1'($urandom_range(0, 1)));
            C_IMM: begin push(4'd10, 1'($urandom_range(0, 1))); push(4'd11, 1'($urandom_range(0, 1))); end
            default: ;
        endcase
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge with the DUT in S_IF.
    task automatic run_instr(input logic [5:0] op, input int w_if, input int w_mem, input int zsel);
        logic [4:0] e;
        exp_q.delete();
        build_seq(op, w_if, w_mem);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            opcode    = op;
            mem_ready = e[4];
            zero      = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            #1;
            check_eq("state", 32'(state), 32'(e[3:0]));
            check_eq("ctrl", 32'(ctrl_w), 32'(exp_ctrl(e[3:0], op, e[4])));
            check_eq("illegal_op", 32'(illegal_op),
                     32'((e[3:0] == 4'd1) && (op_class(op) == C_ILL)));
            check_eq("mem_err", 32'(mem_err), 32'd0);
            @(negedge clk);
        end
    endtask

    logic [5:0] legal_ops [14] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3,
                                    6'd8, 6'd12, 6'd13, 6'd10, 6'd0, 6'd35, 6'd4};

    initial begin
        logic [5:0] op;
        rst_n = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_state", 32'(state), 32'd0);
        check_eq("reset_ctrl", 32'(ctrl_w), 32'd0);
        check_eq("reset_pulses", 32'({illegal_op, mem_err}), 32'd0);
        rst_n = 1'b1;

        // Directed instruction set walk, including the lw stall and both branch flavours.
        run_instr(6'd0, 0, 0, -1);          // R
        run_instr(6'd35, 0, 3, -1);         // lw with 3 stall cycles in S_MRD
        run_instr(6'd43, 1, 2, -1);         // sw
        run_instr(6'd4, 0, 0, 0);           // beq, zero=0
        run_instr(6'd4, 0, 0, 1);           // beq, zero=1
        run_instr(6'd5, 0, 0, 0);           // bne, zero=0
        run_instr(6'd5, 0, 0, 1);           // bne, zero=1
        run_instr(6'd2, 0, 0, -1);          // j
        run_instr(6'd3, 0, 0, -1);          // jal
        run_instr(6'd8, 0, 0, -1);          // addi
        run_instr(6'd12, 0, 0, -1);         // andi
        run_instr(6'd13, 0, 0, -1);         // ori
        run_instr(6'd10, 0, 0, -1);         // slti
        run_instr(6'd63, 0, 0, -1);         // undefined opcode
        check_eq("after_illegal_state", 32'(state), 32'd0);

        // Fetch timeout: four stalled cycles, then the abandon cycle.
        for (int k = 0; k < 4; k++) begin
            opcode = 6'd0; mem_ready = 1'b0;
            #1;
            check_eq("to_wait_state", 32'(state), 32'd0);
            check_eq("to_wait_err", 32'(mem_err), 32'd0);
            check_eq("to_wait_irw", 32'(IRWrite), 32'd0);
            @(negedge clk);
        end
        #1;
        check_eq("to_err", 32'(mem_err), 32'd1);
        check_eq("to_irw", 32'(IRWrite), 32'd0);
        check_eq("to_pcw", 32'(PCWrite), 32'd0);
        @(negedge clk);
        #1;
        check_eq("to_restart_state", 32'(state), 32'd0);
        check_eq("to_restart_err", 32'(mem_err), 32'd0);
        run_instr(6'd0, 2, 0, -1);          // fetch restarts with a fresh wait count

        // Asynchronous reset in the middle of a stalled load.
        opcode = 6'd35; mem_ready = 1'b1;
        repeat (3) @(negedge clk);          // S_IF, S_ID, S_MA
        mem_ready = 1'b0;
        #1;
        check_eq("mid_lw_state", 32'(state), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_state", 32'(state), 32'd0);
        check_eq("async_rst_ctrl", 32'(ctrl_w), 32'd0);
        check_eq("async_rst_memread", 32'(MemRead), 32'd0);
        @(negedge clk);
        check_eq("held_rst_ctrl", 32'(ctrl_w), 32'd0);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        check_eq("release_memread", 32'(MemRead), 32'd1);
        check_eq("release_iord", 32'(IorD), 32'd0);
        run_instr(6'd35, 0, 1, -1);

        // Randomized instruction stream, mostly legal with some random opcodes.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else                           op = legal_ops[$urandom_range(0, 13)];
            run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
